ff_table_ctrl: RTL and testbench



---
 rtl/ff_table_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ff_table_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ff_table_ctrl.sv
// ff_table_ctrl: gates a packet stream so match-table writes only happen
// between packets. A config request waits for the current packet to end,
// lets the forwarded pipeline drain for DRAIN_CYCLES idle cycles, then
// streams up to MAX_BURST table writes before reopening the packet path.
// Optional build macro: FF_TABLE_CTRL_STATS_EN adds saturating write and
// stall counters; without it the stat ports read 0.
module ff_table_ctrl #(
    parameter int FP_DWIDTH    = 128,
    parameter int FP_EWIDTH    = 4,
    parameter int DRAIN_CYCLES = 4,
    parameter int MAX_BURST    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FP_DWIDTH-1:0] s_data,
    input  logic                 s_valid,
    input  logic                 s_sop,
    input  logic                 s_eop,
    input  logic [FP_EWIDTH-1:0] s_empty,
    output logic                 s_ready,
    output logic [FP_DWIDTH-1:0] m_data,
    output logic                 m_valid,
    output logic                 m_sop,
    output logic                 m_eop,
    output logic [FP_EWIDTH-1:0] m_empty,
    input  logic [63:0]          cfg_data,
    input  logic [12:0]          cfg_addr,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic [63:0]          wr_data,
    output logic [12:0]          wr_addr,
    output logic                 wr_en,
    output logic                 busy,
    output logic [31:0]          stat_writes,
    output logic [31:0]          stat_stall_cycles
);

    localparam int DCW = $clog2(DRAIN_CYCLES + 1);
    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
    localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, WAIT_EOP, DRAIN, WRITE} state_t;

    state_t               state_q;
    logic                 in_pkt_q;
    logic                 in_pkt_d;
    logic [DCW-1:0]       drain_q;
    logic [BCW-1:0]       burst_q;
    logic                 s_acc;
    logic                 cfg_acc;

    logic [FP_DWIDTH-1:0] m_data_q;
    logic                 m_valid_q;
    logic                 m_sop_q;
    logic                 m_eop_q;
    logic [FP_EWIDTH-1:0] m_empty_q;
    logic [63:0]          wr_data_q;
    logic [12:0]          wr_addr_q;
    logic                 wr_en_q;

    // Upstream ready: open while waiting for EOP; in IDLE a pending config
    // with no packet open takes priority over a new packet start.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            IDLE:     s_ready = !(cfg_valid && !in_pkt_q);
            WAIT_EOP: s_ready = 1'b1;
            default:  s_ready = 1'b0;
        endcase
    end

    assign s_acc     = s_valid && s_ready;
    assign cfg_ready = (state_q == WRITE);
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign busy      = (state_q != IDLE);

    // Packet-open tracking; a single-beat packet (sop and eop) never opens.
    always_comb begin
        in_pkt_d = in_pkt_q;
        if (s_acc) begin
            if (s_eop)      in_pkt_d = 1'b0;
            else if (s_sop) in_pkt_d = 1'b1;
        end
    end

    // Control FSM with drain and burst counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            in_pkt_q <= 1'b0;
            drain_q  <= '0;
            burst_q  <= '0;
        end else begin
            in_pkt_q <= in_pkt_d;
            drain_q  <= '0;
            case (state_q)
                IDLE: begin
                    if (cfg_valid && !in_pkt_q) begin
                        state_q <= DRAIN;
                    end else if (cfg_valid && in_pkt_q) begin
                        // The closing beat may be accepted in this very cycle.
                        state_q <= (s_acc && s_eop) ? DRAIN : WAIT_EOP;
                    end
                end
                WAIT_EOP: begin
                    if (s_acc && s_eop) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= WRITE;
                        burst_q <= '0;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                WRITE: begin
                    if (!cfg_valid || burst_q == BURST_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        burst_q <= burst_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Single register stage on the packet path; payload loads only on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_sop_q   <= 1'b0;
            m_eop_q   <= 1'b0;
            m_empty_q <= '0;
        end else begin
            m_valid_q <= s_acc;
            if (s_acc) begin
                m_data_q  <= s_data;
                m_sop_q   <= s_sop;
                m_eop_q   <= s_eop;
                m_empty_q <= s_empty;
            end
        end
    end

    // Table write port: one-cycle pulse per accepted config beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= cfg_acc;
            if (cfg_acc) begin
                wr_addr_q <= cfg_addr;
                wr_data_q <= cfg_data;
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_sop   = m_sop_q;
    assign m_eop   = m_eop_q;
    assign m_empty = m_empty_q;
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

`ifdef FF_TABLE_CTRL_STATS_EN
    logic [31:0] stat_writes_q;
    logic [31:0] stat_stall_q;

    // Saturating counters of emitted writes and upstream stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_writes_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (wr_en_q && stat_writes_q != 32'hFFFF_FFFF)
                stat_writes_q <= stat_writes_q + 32'd1;
            if (s_valid && !s_ready && stat_stall_q != 32'hFFFF_FFFF)
                stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_writes       = stat_writes_q;
    assign stat_stall_cycles = stat_stall_q;
`else
    assign stat_writes       = 32'd0;
    assign stat_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_ff_table_ctrl.sv
// Self-checking bench for ff_table_ctrl: a control-vector table for the idle
// write window, then scoreboarded packet/config sequences for the corner cases.
module tb_ff_table_ctrl;

    localparam int DW = 128;
    localparam int EW = 4;
    localparam int DRAIN_CYCLES = 4;
    localparam int MAX_BURST = 16;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid, s_sop, s_eop;
    logic [EW-1:0] s_empty;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid, m_sop, m_eop;
    logic [EW-1:0] m_empty;
    logic [63:0]   cfg_data;
    logic [12:0]   cfg_addr;
    logic          cfg_valid, cfg_ready;
    logic [63:0]   wr_data;
    logic [12:0]   wr_addr;
    logic          wr_en, busy;
    logic [31:0]   stat_writes, stat_stall_cycles;

    ff_table_ctrl #(
        .FP_DWIDTH(DW), .FP_EWIDTH(EW),
        .DRAIN_CYCLES(DRAIN_CYCLES), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop),
        .s_empty(s_empty), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop),
        .m_empty(m_empty),
        .cfg_data(cfg_data), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
        .busy(busy), .stat_writes(stat_writes), .stat_stall_cycles(stat_stall_cycles)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
        int            cyc;
    } beat_t;

    typedef struct {
        logic [12:0] addr;
        logic [63:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic        cfg_valid;
        logic [12:0] addr;
        logic [63:0] data;
        logic        s_valid;
        logic        e_s_ready;
        logic        e_cfg_ready;
        logic        e_busy;
        logic        e_wr_en;
    } vec_t;

    beat_t mq[$];
    wr_t   wq[$];
    int    runs_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    m_seen = 0;
    int    wr_seen = 0;
    int    last_m_cyc = -1000;
    int    run = 0;
    logic  prev_wr = 1'b0;
    int    exp_stat_w = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Observes both output streams and pops the scoreboards.
    task automatic monitor();
        beat_t eb;
        wr_t   ew;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
                prev_wr = 1'b0;
            end else begin
                if (m_valid) begin
                    m_seen++;
                    last_m_cyc = cyc;
                    if (mq.size() == 0) begin
                        chk("m_unexpected", 128'(m_valid), 128'(0));
                    end else begin
                        eb = mq.pop_front();
                        chk("m_data", m_data, eb.data);
                        chk("m_sop", 128'(m_sop), 128'(eb.sop));
                        chk("m_eop", 128'(m_eop), 128'(eb.eop));
                        chk("m_empty", 128'(m_empty), 128'(eb.empty));
                        chk("m_latency", 128'(cyc), 128'(eb.cyc));
                    end
                end
                if (wr_en) begin
                    wr_seen++;
                    run++;
                    chk("m_wr_overlap", 128'(m_valid), 128'(0));
                    if (!prev_wr)
                        chk("drain_gap", 128'((cyc - last_m_cyc) > DRAIN_CYCLES), 128'(1));
                    if (wq.size() == 0) begin
                        chk("wr_unexpected", 128'(wr_en), 128'(0));
                    end else begin
                        ew = wq.pop_front();
                        chk("wr_addr", 128'(wr_addr), 128'(ew.addr));
                        chk("wr_data", 128'(wr_data), 128'(ew.data));
                        chk("wr_latency", 128'(cyc), 128'(ew.cyc));
                    end
                end else if (run > 0) begin
                    runs_q.push_back(run);
                    run = 0;
                end
                prev_wr = wr_en;
            end
        end
    endtask

    // Drives one packet; entered and left at posedge+1.
    task automatic send_pkt(input int n, input int tag, output int first_cyc);
        beat_t b;
        logic  acc;
        int    w;
        first_cyc = -1;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_sop   = (i == 0);
            s_eop   = (i == n - 1);
            s_empty = (i == n - 1) ? EW'(tag) : '0;
            s_data  = {$urandom(), $urandom(), 32'(tag), 32'(i)};
            acc = 1'b0;
            w = 0;
            while (!acc) begin
                @(negedge clk);
                acc = s_ready;
                @(posedge clk);
                #1;
                if (!acc) begin
                    w++;
                    if (w > 200) begin
                        chk("pkt_timeout", 128'(w), 128'(0));
                        s_valid = 1'b0;
                        return;
                    end
                end
            end
            b.data = s_data; b.sop = s_sop; b.eop = s_eop; b.empty = s_empty; b.cyc = cyc;
            mq.push_back(b);
            if (i == 0) first_cyc = cyc;
        end
        s_valid = 1'b0;
        s_sop = 1'b0;
        s_eop = 1'b0;
    endtask

    // Drives a config burst; cfg_valid stays high between beats.
    task automatic send_cfg(input int n, input logic [12:0] base, output int last_cyc);
        wr_t  e;
        logic acc;
        int   w;
        last_cyc = -1;
        for (int i = 0; i < n; i++) begin
            cfg_valid = 1'b1;
            cfg_addr  = base + 13'(i);
            cfg_data  = {$urandom(), $urandom()};
            acc = 1'b0;
            w = 0;
            while (!acc) begin
                @(negedge clk);
                acc = cfg_ready;
                @(posedge clk);
                #1;
                if (!acc) begin
                    w++;
                    if (w > 200) begin
                        chk("cfg_timeout", 128'(w), 128'(0));
                        cfg_valid = 1'b0;
                        return;
                    end
                end
            end
            e.addr = cfg_addr; e.data = cfg_data; e.cyc = cyc;
            wq.push_back(e);
            exp_stat_w++;
            last_cyc = cyc;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    vec_t tbl[9];
    int   pc, cc, base_w, base_m;
    wr_t  e;

    initial begin
        rst = 1'b1;
        s_data = '0; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_empty = '0;
        cfg_data = '0; cfg_addr = '0; cfg_valid = 1'b0;

        // Idle write window, cycle by cycle; vector 0 also collides with a packet start.
        tbl[0] = '{1'b1, 13'h0010, 64'hDEAD_BEEF_0000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 13'h0010, 64'hDEAD_BEEF_0000_0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 13'h0010, 64'hDEAD_BEEF_0000_0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 13'h0010, 64'hDEAD_BEEF_0000_0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 13'h0010, 64'hDEAD_BEEF_0000_0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 13'h0010, 64'hDEAD_BEEF_0000_0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 13'h1FFF, 64'hFFFF_0000_1234_1FFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 13'h0000, 64'h0,                   1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 13'h0000, 64'h0,                   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        fork
            monitor();
        join_none

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_m_sop", 128'(m_sop), 128'(0));
        chk("rst_m_eop", 128'(m_eop), 128'(0));
        chk("rst_m_data", m_data, 128'(0));
        chk("rst_m_empty", 128'(m_empty), 128'(0));
        chk("rst_wr_en", 128'(wr_en), 128'(0));
        chk("rst_wr_addr", 128'(wr_addr), 128'(0));
        chk("rst_wr_data", 128'(wr_data), 128'(0));
        chk("rst_cfg_ready", 128'(cfg_ready), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_stat_writes", 128'(stat_writes), 128'(0));
        chk("rst_stat_stall", 128'(stat_stall_cycles), 128'(0));
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven idle write.
        for (int i = 0; i < 9; i++) begin
            cfg_valid = tbl[i].cfg_valid;
            cfg_addr  = tbl[i].addr;
            cfg_data  = tbl[i].data;
            s_valid   = tbl[i].s_valid;
            s_sop     = tbl[i].s_valid;
            s_eop     = tbl[i].s_valid;
            s_data    = {4{32'hA5A5_0000 + 32'(i)}};
            @(negedge clk);
            chk($sformatf("v%0d_s_ready", i), 128'(s_ready), 128'(tbl[i].e_s_ready));
            chk($sformatf("v%0d_cfg_ready", i), 128'(cfg_ready), 128'(tbl[i].e_cfg_ready));
            chk($sformatf("v%0d_busy", i), 128'(busy), 128'(tbl[i].e_busy));
            chk($sformatf("v%0d_wr_en", i), 128'(wr_en), 128'(tbl[i].e_wr_en));
            @(posedge clk);
            #1;
            if (tbl[i].cfg_valid && tbl[i].e_cfg_ready) begin
                e.addr = tbl[i].addr; e.data = tbl[i].data; e.cyc = cyc;
                wq.push_back(e);
                exp_stat_w++;
            end
        end
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
        idle(2);

        // Pass-through: 3-beat packet with no config.
        base_w = wr_seen;
        send_pkt(3, 1, pc);
        idle(3);
        chk("pass_no_wr", 128'(wr_seen - base_w), 128'(0));

        // Single-beat packet leaves no packet open; config follows directly.
        send_pkt(1, 2, pc);
        send_cfg(1, 13'h0100, cc);
        idle(3);

        // Config raised on beat 2 of a 5-beat packet.
        base_m = m_seen;
        fork
            send_pkt(5, 3, pc);
            begin
                @(posedge clk);
                #1;
                send_cfg(2, 13'h0200, cc);
            end
        join
        idle(4);
        chk("midpkt_beats", 128'(m_seen - base_m), 128'(5));

        // Config and packet start in the same idle cycle: packet waits.
        fork
            send_pkt(3, 4, pc);
            send_cfg(2, 13'h0300, cc);
        join
        chk("collision_order", 128'(pc > cc), 128'(1));
        idle(4);

        // Burst limit: 20 back-to-back beats split into 16 + 4.
        runs_q.delete();
        send_cfg(20, 13'h0400, cc);
        idle(4);
        chk("burst_runs", 128'(runs_q.size()), 128'(2));
        if (runs_q.size() == 2) begin
            chk("burst_run0", 128'(runs_q[0]), 128'(MAX_BURST));
            chk("burst_run1", 128'(runs_q[1]), 128'(4));
        end

        // Reset while the third write of a burst is being presented.
        base_w = wr_seen;
        cfg_valid = 1'b1;
        cfg_addr = 13'h0500;
        cfg_data = {$urandom(), $urandom()};
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (cfg_ready) break;
            @(posedge clk);
            #1;
        end
        chk("rstb_reached_write", 128'(cfg_ready), 128'(1));
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            e.addr = cfg_addr; e.data = cfg_data; e.cyc = cyc;
            wq.push_back(e);
            cfg_addr = cfg_addr + 13'd1;
            cfg_data = {$urandom(), $urandom()};
            if (k == 0) @(negedge clk);
        end
        @(negedge clk);
        #1 rst = 1'b1;
        exp_stat_w = 0;
        #1;
        chk("rstb_wr_en", 128'(wr_en), 128'(0));
        chk("rstb_cfg_ready", 128'(cfg_ready), 128'(0));
        chk("rstb_busy", 128'(busy), 128'(0));
        chk("rstb_wr_addr", 128'(wr_addr), 128'(0));
        cfg_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstb_idle_after", 128'(busy), 128'(0));
        chk("rstb_two_writes", 128'(wr_seen - base_w), 128'(2));
        chk("rstb_wq_empty", 128'(wq.size()), 128'(0));
        @(posedge clk);
        #1;

        // Recovery after reset.
        send_pkt(2, 5, pc);
        send_cfg(1, 13'h0600, cc);
        idle(6);

        chk("end_mq_empty", 128'(mq.size()), 128'(0));
        chk("end_wq_empty", 128'(wq.size()), 128'(0));
`ifdef FF_TABLE_CTRL_STATS_EN
        chk("stat_writes", 128'(stat_writes), 128'(exp_stat_w));
`else
        chk("stat_writes_off", 128'(stat_writes), 128'(0));
        chk("stat_stall_off", 128'(stat_stall_cycles), 128'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
